// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / decoded-entry-out handshake bundle for imm_gen_pipe.
// The master side feeds instructions and consumes entries. The slave side is the decoder.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [31:0]     out_instr;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator that feeds a 2-entry skid buffer (EMPTY/ONE/TWO).
// Define IMM_GEN_PIPE_CSR_EN to decode SYSTEM (CSR) opcodes. Without it, those opcodes decode as illegal.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_NONE = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [31:0]     instr;
    } entry_t;

    state_e             r_state;
    state_e             w_state_nxt;
    entry_t             r_head;
    entry_t             r_skid;
    entry_t             w_dec;
    fmt_e               w_fmt;
    logic signed [31:0] w_imm32;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_pop;

    // ---------------- decode ----------------
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_fmt = FMT_NONE;
        case (bus.in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: w_fmt = FMT_I;
            7'b0100011:                         w_fmt = FMT_S;
            7'b1100011:                         w_fmt = FMT_B;
            7'b0110111, 7'b0010111:             w_fmt = FMT_U;
            7'b1101111:                         w_fmt = FMT_J;
            7'b0110011:                         w_fmt = FMT_R;
            7'b0011011: if (XLEN == 64)         w_fmt = FMT_I;
            7'b0111011: if (XLEN == 64)         w_fmt = FMT_R;
`ifdef IMM_GEN_PIPE_CSR_EN
            7'b1110011: w_fmt = (bus.in_instr[14:12] != 3'b000) ? FMT_Z : FMT_I;
`else
            7'b1110011: w_fmt = FMT_NONE;
`endif
            default:                            w_fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
            FMT_S: w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
            FMT_B: w_imm32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                              bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
            FMT_U: w_imm32 = {bus.in_instr[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                              bus.in_instr[20], bus.in_instr[30:21], 1'b0};
            FMT_Z: w_imm32 = {27'b0, bus.in_instr[19:15]};
            default: w_imm32 = '0;
        endcase
    end

    // The 32-bit immediate is signed, so the size cast sign-extends it to XLEN (U-type included).
    always_comb begin
        w_dec.imm     = XLEN'(w_imm32);
        w_dec.fmt     = w_fmt;
        w_dec.illegal = (w_fmt == FMT_NONE);
        w_dec.instr   = bus.in_instr;
    end

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_accept && !w_pop)      w_state_nxt = S_TWO;
                    else if (!w_accept && w_pop) w_state_nxt = S_EMPTY;
                end
                S_TWO:   if (w_pop) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_in_ready  = (r_state != S_TWO);
        w_out_valid = (r_state != S_EMPTY);
    end

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_pop    = w_out_valid && bus.out_ready;

    // ---------------- entry storage ----------------
    // NOTE: both buffer slots are reset because the outputs must read zero during reset.
    // The head only changes when it is empty or is being popped, so a stalled entry holds steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else if (!flush) begin
            case (r_state)
                S_EMPTY: if (w_accept) r_head <= w_dec;
                S_ONE: begin
                    if (w_accept && w_pop) r_head <= w_dec;
                    else if (w_accept)     r_skid <= w_dec;
                end
                S_TWO:   if (w_pop) r_head <= r_skid;
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_imm     = r_head.imm;
    assign bus.out_fmt     = r_head.fmt;
    assign bus.out_illegal = r_head.illegal;
    assign bus.out_instr   = r_head.instr;
endmodule
